// File: rtl/mult_add_pkg.sv
// Shared definitions for the iterative multiply-add core: default width,
// FSM state encoding and the bit-counter width.
package mult_add_pkg;

   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      ADD  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Width of a counter that indexes the multiplier bits; never below 1.
   function automatic int cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int CNT_W = cnt_w(DATA_W_DEF);

endpackage

// File: rtl/mult_add_shift_mul.sv
// Radix-2 shift-add datapath: latches operands, walks the multiplier LSB
// first, then folds in the addend and registers the final result.
module mult_add_shift_mul
   import mult_add_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  load,
   input  logic                  step,
   input  logic                  add,
   input  logic [DATA_W-1:0]     op_a,
   input  logic [DATA_W-1:0]     op_b,
   input  logic [DATA_W-1:0]     op_c,
   output logic                  last,
   output logic [2*DATA_W-1:0]   res,
   output logic                  res_hi_nz
);

   localparam int CW = cnt_w(DATA_W);

   logic [DATA_W-1:0]   b_q;
   logic [DATA_W-1:0]   c_q;
   logic [2*DATA_W-1:0] a_sh;
   logic [2*DATA_W-1:0] acc;
   logic [2*DATA_W-1:0] sum;
   logic [CW-1:0]       cnt;

   assign last = (cnt == CW'(DATA_W - 1));
   assign sum  = acc + {{DATA_W{1'b0}}, c_q};

   // a_sh always holds op_a shifted left by cnt, so no barrel shifter is needed.
   always_ff @(posedge clk) begin
      if (rst) begin
         b_q       <= '0;
         c_q       <= '0;
         a_sh      <= '0;
         acc       <= '0;
         cnt       <= '0;
         res       <= '0;
         res_hi_nz <= 1'b0;
      end else if (clear) begin
         acc <= '0;
         cnt <= '0;
      end else if (load) begin
         a_sh <= {{DATA_W{1'b0}}, op_a};
         b_q  <= op_b;
         c_q  <= op_c;
         acc  <= '0;
         cnt  <= '0;
      end else if (step) begin
         if (b_q[cnt]) begin
            acc <= acc + a_sh;
         end
         a_sh <= a_sh << 1;
         cnt  <= last ? '0 : cnt + CW'(1);
      end else if (add) begin
         res       <= sum;
         res_hi_nz <= |sum[2*DATA_W-1:DATA_W];
      end
   end

endmodule

// File: rtl/mult_add_core.sv
// Multiply-add unit (op_a*op_b+op_c) with a fixed-latency FSM and
// valid/ready handshakes on operand and result sides.
module mult_add_core
   import mult_add_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  clear,
   input  logic [DATA_W-1:0]     op_a,
   input  logic [DATA_W-1:0]     op_b,
   input  logic [DATA_W-1:0]     op_c,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [2*DATA_W-1:0]   res,
   output logic                  res_hi_nz,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output state_t                state_dbg
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; ready never depends combinationally on valid on either side.

   state_t state;
   state_t state_nxt;
   logic   accept;
   logic   last;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign state_dbg = state;
   assign accept    = (state == IDLE) && in_valid && !clear;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (in_valid)  state_nxt = MULT;
         MULT: if (last)      state_nxt = ADD;
         ADD:                 state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default:             state_nxt = IDLE;
      endcase
      // Abort wins over everything except reset, including an IDLE accept.
      if (clear) begin
         state_nxt = IDLE;
      end
   end

   mult_add_shift_mul #(
      .DATA_W (DATA_W)
   ) u_shift_mul (
      .clk       (ACLK),
      .rst       (ARESET),
      .clear     (clear),
      .load      (accept),
      .step      (state == MULT),
      .add       (state == ADD),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_c      (op_c),
      .last      (last),
      .res       (res),
      .res_hi_nz (res_hi_nz)
   );

endmodule

// File: doc/mult_add_core.md
MULT_ADD_CORE -- requirements
Module: mult_add_core

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the operand width in bits.
REQ-002 SHALL have port ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port ARESET, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port clear, input, 1 bit: synchronous abort of any operation in progress.
REQ-005 SHALL have ports op_a, op_b, op_c, input, DATA_W bits each: unsigned operands captured from the register file.
REQ-006 SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit: operand handshake.
REQ-007 SHALL have port res, output, 2*DATA_W bits: the result op_a*op_b+op_c.
REQ-008 SHALL have port res_hi_nz, output, 1 bit: high when res[2*DATA_W-1:DATA_W] is nonzero.
REQ-009 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: result handshake.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 SHALL implement a four-state FSM: IDLE, MULT, ADD, DONE.
REQ-012 in_ready SHALL equal (state==IDLE), with no combinational path from in_valid.
REQ-013 IDLE with in_valid: at that edge, SHALL latch op_a, op_b, op_c, clear the accumulator, zero the bit counter and go to MULT.
REQ-014 MULT SHALL use radix-2 shift-add, one multiplier bit per cycle, LSB first; the accumulator adds op_a shifted left by the counter when that op_b bit is 1.
REQ-015 MULT SHALL last exactly DATA_W cycles with no early termination; the counter then wraps to 0 and the state goes to ADD.
REQ-016 ADD SHALL add zero-extended op_c to the accumulator in one cycle, then go to DONE.
REQ-017 Result width SHALL be 2*DATA_W with no overflow possible, since (2^N-1)^2+(2^N-1) < 2^(2N).
REQ-018 DONE SHALL assert out_valid; res and res_hi_nz are registered and stable while out_valid is high.
REQ-019 DONE with out_ready: at that edge SHALL return to IDLE and deassert out_valid; with out_ready low it holds indefinitely.
REQ-020 Fixed latency: out_valid SHALL first be high DATA_W+2 rising edges after the accepting edge, the accepting edge counted as edge 1.
REQ-021 in_valid outside IDLE SHALL be ignored, and latched operands SHALL not change.
REQ-022 A new operand set SHALL NOT be accepted on the same edge as a DONE-to-IDLE transition; acceptance needs a separate IDLE cycle.
REQ-023 clear SHALL force IDLE at the next edge from any state, deassert out_valid and discard the partial result; res is unchanged.
REQ-024 clear and in_valid together in IDLE: clear SHALL win and no operands are accepted.

Reset
REQ-025 ARESET high at a rising edge SHALL set state IDLE, out_valid 0, busy 0, res 0, res_hi_nz 0 and the counter 0; in_ready is 1 from the first post-reset cycle.
REQ-026 Reset SHALL take priority over clear and over the handshakes, including mid-MULT.

Structure
REQ-027 A shared package mult_add_pkg SHALL hold the DATA_W default, the FSM state enum and the counter-width constant $clog2(DATA_W).
REQ-028 The iterative shift-add datapath (accumulator, shifter, counter) SHALL live in one sub-module, mult_add_shift_mul; the top level holds the FSM and handshakes.

Verification
REQ-029 A=3, B=4, C=5 -> res=0x0000000000000011, res_hi_nz=0, out_valid first high on edge 34 after acceptance.
REQ-030 A=B=C=0xFFFFFFFF -> res=0xFFFFFFFF00000000, res_hi_nz=1.
REQ-031 A=0, B=0x12345678, C=0xDEADBEEF -> res=0x00000000DEADBEEF; then A=0x10000, B=0x10000, C=0 -> res=0x0000000100000000, res_hi_nz=1.
REQ-032 out_ready low for 10 cycles in DONE -> out_valid and res held; in_ready stays 0; second operands presented meanwhile are not taken until one IDLE cycle after release.
REQ-033 clear pulsed on MULT cycle 10 -> IDLE next edge, out_valid never high; the next op A=2, B=3, C=1 gives res=7.
REQ-034 ARESET asserted mid-MULT -> all outputs at reset values next edge; an in_valid held during reset is not accepted.
